// File: rtl/mult_arb_pkg.sv
// Shared constants and the tag bundle for the multiplier arbiter.
// No ports: imported by mult_arbiter and rr_picker.
package mult_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int MULT_LATENCY    = 2;
  localparam int ID_WIDTH        = $clog2(NUM_REQ_DEFAULT);

  // Tag ids are sized for the largest supported requester count (8),
  // so the same tag type serves every legal NUM_REQ.
  localparam int TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from ptr_i+1 upwards.
// Ports: req_i request vector, ptr_i last winner; gnt_o one-hot, id_o, any_o.
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEFAULT,
  parameter int W = ID_WIDTH
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] id_o,
  output logic         any_o
);

  logic [W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = '0;
    // ptr_i itself is visited last, giving it lowest priority
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external 2-stage freezable multiplier.
// Ports: req_* request side, rsp_* response side, mult_* multiplier side,
// in_flight = number of valid pipeline tags.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int P_WIDTH = 18
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ-1:0][B_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic signed [P_WIDTH-1:0]        rsp_p,
  output logic [A_WIDTH-1:0]               mult_a,
  output logic [B_WIDTH-1:0]               mult_b,
  output logic                             mult_freeze,
  input  logic signed [P_WIDTH-1:0]        mult_p,
  output logic [1:0]                       in_flight
);

  localparam int IDW = $clog2(NUM_REQ);

  tag_t               s1_q, s1_d;
  tag_t               s2_q, s2_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_any;

  // Stage2 tag decodes straight to the one-hot response valid.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = s2_q.valid && (s2_q.id == TAG_ID_W'(i));
    end
  end

  // Freeze only when the owner of the stage2 result is not taking it.
  assign mult_freeze = |(rsp_valid & ~rsp_ready);
  assign rsp_p       = mult_p;
  assign in_flight   = {1'b0, s1_q.valid} + {1'b0, s2_q.valid};

  // Reset gating keeps req_ready and operands at zero while held in reset.
  assign pick_req = req_valid & {NUM_REQ{rst_n_in & ~mult_freeze}};

  rr_picker #(
    .N(NUM_REQ),
    .W(IDW)
  ) u_picker (
    .req_i(pick_req),
    .ptr_i(rr_ptr_q),
    .gnt_o(gnt),
    .id_o (gnt_id),
    .any_o(gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    mult_a = '0;
    mult_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mult_a = req_a[i];
        mult_b = req_b[i];
      end
    end
  end

  always_comb begin
    s1_d     = s1_q;
    s2_d     = s2_q;
    rr_ptr_d = rr_ptr_q;
    if (!mult_freeze) begin
      s2_d = s1_q;
      s1_d = '{valid: gnt_any, id: TAG_ID_W'(gnt_id)};
      if (gnt_any) rr_ptr_d = gnt_id;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_q     <= '0;
      s2_q     <= '0;
      rr_ptr_q <= IDW'(NUM_REQ - 1);
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a Q2.14 2-stage multiplier stub.
// Table vectors, directed corner sequences and randomized model checks.
module tb_mult_arbiter;

  localparam int N = 4;

  logic                 clk_in   = 1'b0;
  logic                 rst_n_in = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N-1:0][15:0]   req_a = '0;
  logic [N-1:0][15:0]   req_b = '0;
  logic [N-1:0]         rsp_valid;
  logic [N-1:0]         rsp_ready = '0;
  logic signed [17:0]   rsp_p;
  logic [15:0]          mult_a;
  logic [15:0]          mult_b;
  logic                 mult_freeze;
  logic signed [17:0]   mult_p;
  logic [1:0]           in_flight;

  always #5 clk_in = ~clk_in;

  mult_arbiter #(
    .NUM_REQ(N), .A_WIDTH(16), .B_WIDTH(16), .P_WIDTH(18)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_p      (rsp_p),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_freeze(mult_freeze),
    .mult_p     (mult_p),
    .in_flight  (in_flight)
  );

  // External freezable multiplier: Q2.14 x Q2.14 -> Q4.14, 2 stages.
  logic signed [17:0] m1 = '0;
  logic signed [17:0] m2 = '0;

  function automatic logic signed [17:0] q14(input logic [15:0] a,
                                             input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[31:14];
  endfunction

  always @(posedge clk_in) begin
    if (!mult_freeze) begin
      m1 <= q14(mult_a, mult_b);
      m2 <= m1;
    end
  end
  assign mult_p = m2;

  // Reference model: ordered list of accepted operations and their ages.
  typedef struct {
    int         id;
    logic [17:0] p;
    int         age;
  } op_t;

  op_t inf[$];
  int  ptr = N - 1;
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;

  logic [N-1:0] e_rdy, e_rspv;
  logic         e_frz;
  logic [17:0]  e_p;
  logic [15:0]  e_a, e_b;
  logic [1:0]   e_inf;
  int           e_gnt;

  function automatic logic [17:0] ref_p(input logic [15:0] a,
                                        input logic [15:0] b);
    int ai, bi, pr;
    ai = int'($signed(a));
    bi = int'($signed(b));
    pr = (ai * bi) >>> 14;
    return 18'(pr);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h",
                  nm, cyc, act, exp);
  endtask

  task automatic model_eval();
    e_frz  = 1'b0;
    e_rspv = '0;
    e_p    = '0;
    e_gnt  = -1;
    if (inf.size() > 0 && inf[0].age == 2) begin
      e_rspv[inf[0].id] = 1'b1;
      e_p   = inf[0].p;
      e_frz = !rsp_ready[inf[0].id];
    end
    if (!e_frz) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (e_gnt < 0 && req_valid[c]) e_gnt = c;
      end
    end
    e_rdy = '0;
    e_a   = '0;
    e_b   = '0;
    if (e_gnt >= 0) begin
      e_rdy[e_gnt] = 1'b1;
      e_a = req_a[e_gnt];
      e_b = req_b[e_gnt];
    end
    e_inf = 2'(inf.size());
  endtask

  task automatic model_check();
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("mult_freeze", 32'(mult_freeze), 32'(e_frz));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rspv));
    chk("in_flight", 32'(in_flight), 32'(e_inf));
    chk("mult_a", 32'(mult_a), 32'(e_a));
    chk("mult_b", 32'(mult_b), 32'(e_b));
    if (e_rspv != '0) chk("rsp_p", {14'd0, rsp_p}, {14'd0, e_p});
  endtask

  task automatic model_advance();
    op_t o;
    if (!e_frz) begin
      if (e_rspv != '0) void'(inf.pop_front());
      foreach (inf[i]) inf[i].age++;
      if (e_gnt >= 0) begin
        o.id  = e_gnt;
        o.p   = ref_p(req_a[e_gnt], req_b[e_gnt]);
        o.age = 1;
        inf.push_back(o);
        ptr = e_gnt;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0] rr,
                      input bit rnd);
    @(negedge clk_in);
    req_valid = v;
    rsp_ready = rr;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        req_a[i] = 16'($urandom);
        req_b[i] = 16'($urandom);
      end
    end
    #1;
    model_eval();
    model_check();
    model_advance();
    cyc++;
  endtask

  // Assert reset mid-cycle with requests pending; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk_in);
    #2;
    req_valid = '1;
    rsp_ready = '0;
    rst_n_in  = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mult_a", 32'(mult_a), 32'h0);
    chk("rst_mult_b", 32'(mult_b), 32'h0);
    chk("rst_freeze", 32'(mult_freeze), 32'h0);
    chk("rst_in_flight", 32'(in_flight), 32'h0);
    inf.delete();
    ptr = N - 1;
    @(negedge clk_in);
    req_valid = '0;
    rsp_ready = '1;
    #2;
    rst_n_in = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] rr;
    logic [N-1:0] rdy;
    logic         frz;
    logic [N-1:0] rspv;
    logic [1:0]   inf;
    logic [17:0]  p;
  } vec_t;

  vec_t tbl[17];
  int   rsp_cnt;

  initial begin
    // Row fields: valid, rsp_ready, req_ready, freeze, rsp_valid, in_flight, p
    tbl[0]  = '{4'hF, 4'hF, 4'h1, 1'b0, 4'h0, 2'd0, 18'h0};
    tbl[1]  = '{4'hF, 4'hF, 4'h2, 1'b0, 4'h0, 2'd1, 18'h0};
    tbl[2]  = '{4'hF, 4'hF, 4'h4, 1'b0, 4'h1, 2'd2, 18'h02000};
    tbl[3]  = '{4'hF, 4'hF, 4'h8, 1'b0, 4'h2, 2'd2, 18'h3E000};
    tbl[4]  = '{4'hF, 4'hF, 4'h1, 1'b0, 4'h4, 2'd2, 18'h01000};
    tbl[5]  = '{4'hF, 4'hF, 4'h2, 1'b0, 4'h8, 2'd2, 18'h00800};
    tbl[6]  = '{4'h4, 4'hF, 4'h4, 1'b0, 4'h1, 2'd2, 18'h02000};
    tbl[7]  = '{4'h0, 4'hF, 4'h0, 1'b0, 4'h2, 2'd2, 18'h3E000};
    tbl[8]  = '{4'h0, 4'hF, 4'h0, 1'b0, 4'h4, 2'd1, 18'h01000};
    tbl[9]  = '{4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 2'd0, 18'h0};
    tbl[10] = '{4'h2, 4'hF, 4'h2, 1'b0, 4'h0, 2'd0, 18'h0};
    tbl[11] = '{4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 2'd1, 18'h0};
    tbl[12] = '{4'hF, 4'hD, 4'h0, 1'b1, 4'h2, 2'd1, 18'h3E000};
    tbl[13] = '{4'hF, 4'hD, 4'h0, 1'b1, 4'h2, 2'd1, 18'h3E000};
    tbl[14] = '{4'hF, 4'hD, 4'h0, 1'b1, 4'h2, 2'd1, 18'h3E000};
    tbl[15] = '{4'h0, 4'hF, 4'h0, 1'b0, 4'h2, 2'd1, 18'h3E000};
    tbl[16] = '{4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 2'd0, 18'h0};

    // req0 = 1.0, req1 = -1.0, req2 = 0.5, req3 = 0.25; all b = 0.5
    req_a[0] = 16'h4000;
    req_a[1] = 16'hC000;
    req_a[2] = 16'h2000;
    req_a[3] = 16'h1000;
    for (int i = 0; i < N; i++) req_b[i] = 16'h2000;

    do_reset();

    // Fairness, single request, then backpressure on requester 1.
    for (int r = 0; r < 17; r++) begin
      step(tbl[r].v, tbl[r].rr, 1'b0);
      chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d_freeze", r), 32'(mult_freeze), 32'(tbl[r].frz));
      chk($sformatf("tbl%0d_rspv", r), 32'(rsp_valid), 32'(tbl[r].rspv));
      chk($sformatf("tbl%0d_infl", r), 32'(in_flight), 32'(tbl[r].inf));
      if (tbl[r].rspv != '0)
        chk($sformatf("tbl%0d_p", r), {14'd0, rsp_p}, {14'd0, tbl[r].p});
    end

    // Retire and accept every cycle: ten back-to-back responses.
    rsp_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step(c < 10 ? 4'hF : 4'h0, 4'hF, 1'b0);
      if (c >= 2) chk("burst_no_bubble", 32'(rsp_valid != '0), 32'h1);
      if (rsp_valid != '0) rsp_cnt++;
    end
    chk("burst_rsp_count", 32'(rsp_cnt), 32'd10);

    // Reset with a full pipeline: nothing may come out afterwards.
    step(4'hF, 4'hF, 1'b0);
    step(4'hF, 4'hF, 1'b0);
    step(4'hF, 4'hF, 1'b0);
    chk("pre_reset_infl", 32'(in_flight), 32'd2);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step(4'h0, 4'hF, 1'b0);
      chk("post_reset_quiet", 32'(rsp_valid), 32'h0);
    end
    step(4'hF, 4'hF, 1'b0);
    chk("first_grant_req0", 32'(req_ready), 32'h1);
    for (int c = 0; c < 3; c++) step(4'h0, 4'hF, 1'b0);

    // Wrap 3 -> 0, then idle; pointer must hold at 0.
    do_reset();
    step(4'h8, 4'hF, 1'b0);
    chk("wrap_grant3", 32'(req_ready), 32'h8);
    step(4'h1, 4'hF, 1'b0);
    chk("wrap_grant0", 32'(req_ready), 32'h1);
    for (int c = 0; c < 4; c++) step(4'h0, 4'hF, 1'b0);
    chk("idle_drained", 32'(in_flight), 32'd0);
    step(4'h6, 4'hF, 1'b0);
    chk("idle_ptr_held", 32'(req_ready), 32'h2);

    // Randomized traffic with occasional backpressure.
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] rr;
      for (int i = 0; i < N; i++) rr[i] = ($urandom_range(0, 3) != 0);
      step(N'($urandom), rr, 1'b1);
    end
    for (int c = 0; c < 4; c++) step(4'h0, 4'hF, 1'b0);
    chk("final_model_empty", 32'(inf.size()), 32'd0);
    chk("final_in_flight", 32'(in_flight), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
